// File: rtl/regfile_write_arbiter_if.sv
// Handshake and regfile write-port bundle for regfile_write_arbiter.
// master = requesters/regfile side, slave = the arbiter.
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_ready;
    logic                  kb_valid;
    logic [ADDR_WIDTH-1:0] kb_addr;
    logic [DATA_WIDTH-1:0] kb_data;
    logic                  kb_ready;
    logic                  rf_wrenable;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0] rf_data;
    logic                  init_done;

    modport master (
        output wb_valid, wb_addr, wb_data, kb_valid, kb_addr, kb_data,
        input  wb_ready, kb_ready, rf_wrenable, rf_addr, rf_data, init_done
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, kb_valid, kb_addr, kb_data,
        output wb_ready, kb_ready, rf_wrenable, rf_addr, rf_data, init_done
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Regfile write-port arbiter: clears regs 1..NUM_REGS-1 after reset, then shares the
// port between writeback (req 0) and key injector (req 1). Define RR_ARB_EN for round-robin.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input logic                    clk,
    input logic                    reset,
    regfile_write_arbiter_if.slave bus
);
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  wb_acc;
    logic                  kb_acc;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;

`ifdef RR_ARB_EN
    logic last_grant; // 0 = writeback, 1 = injector

    always_comb begin
        bus.wb_ready = 1'b0;
        bus.kb_ready = 1'b0;
        if (state == RUN) begin
            bus.wb_ready = !bus.kb_valid || last_grant;
            bus.kb_ready = !bus.wb_valid || !last_grant;
        end
    end
`else
    always_comb begin
        bus.wb_ready = 1'b0;
        bus.kb_ready = 1'b0;
        if (state == RUN) begin
            bus.wb_ready = 1'b1;
            bus.kb_ready = !bus.wb_valid;
        end
    end
`endif

    always_comb begin
        wb_acc   = bus.wb_valid && bus.wb_ready;
        kb_acc   = bus.kb_valid && bus.kb_ready;
        win_addr = wb_acc ? bus.wb_addr : bus.kb_addr;
        win_data = wb_acc ? bus.wb_data : bus.kb_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= INIT;
            cnt             <= ADDR_WIDTH'(1);
            bus.rf_wrenable <= 1'b0;
            bus.rf_addr     <= '0;
            bus.rf_data     <= '0;
            bus.init_done   <= 1'b0;
`ifdef RR_ARB_EN
            last_grant      <= 1'b1;
`endif
        end else begin
            case (state)
                INIT: begin
                    bus.rf_wrenable <= 1'b1;
                    bus.rf_addr     <= cnt;
                    bus.rf_data     <= '0;
                    cnt             <= cnt + 1'b1;
                    if (cnt == LAST_REG) begin
                        state         <= RUN;
                        bus.init_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (wb_acc || kb_acc) begin
                        // Register-0 writes complete the handshake but never pulse wrenable
                        bus.rf_wrenable <= |win_addr;
                        bus.rf_addr     <= win_addr;
                        bus.rf_data     <= win_data;
`ifdef RR_ARB_EN
                        last_grant      <= kb_acc;
`endif
                    end else begin
                        bus.rf_wrenable <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus pushes expected writes,
// a negedge monitor pops and compares every rf_wrenable pulse.
module tb_regfile_write_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    int   wi;
    int   ki;
    wr_t  exp_q[$];

    regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    regfile_write_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_REGS  (NR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: every write pulse must match the head of the expected queue
    always @(negedge clk) begin : monitor
        wr_t e;
        if (bus.rf_wrenable === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write (t=%0t)",
                         bus.rf_addr, bus.rf_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.rf_addr), 32'(e.a));
                check("wr_data", bus.rf_data, e.d);
            end
        end
    end

    task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic kv, input logic [AW-1:0] ka, input logic [DW-1:0] kd,
                        input logic ewr, input logic ekr);
        bus.wb_valid = wv; bus.wb_addr = wa; bus.wb_data = wd;
        bus.kb_valid = kv; bus.kb_addr = ka; bus.kb_data = kd;
        #1;
        if (wv) check("wb_ready", 32'(bus.wb_ready), 32'(ewr));
        if (kv) check("kb_ready", 32'(bus.kb_ready), 32'(ekr));
        if (wv && ewr) begin
            if (wa != '0) exp_q.push_back(wr_t'{a: wa, d: wd});
        end else if (kv && ekr) begin
            if (ka != '0) exp_q.push_back(wr_t'{a: ka, d: kd});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.wb_valid = 1'b0;
        bus.kb_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_state();
        check("rst_wrenable", 32'(bus.rf_wrenable), 32'd0);
        check("rst_addr", 32'(bus.rf_addr), 32'd0);
        check("rst_data", bus.rf_data, 32'd0);
        check("rst_init_done", 32'(bus.init_done), 32'd0);
        check("rst_wb_ready", 32'(bus.wb_ready), 32'd0);
        check("rst_kb_ready", 32'(bus.kb_ready), 32'd0);
    endtask

    // Called at the negedge where reset drops; requests stay raised to prove INIT refuses them
    task automatic run_init();
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hDEAD_0003;
        bus.kb_valid = 1'b1; bus.kb_addr = 5'd4; bus.kb_data = 32'hDEAD_0004;
        for (int k = 1; k < NR; k++) exp_q.push_back(wr_t'{a: AW'(k), d: '0});
        for (int k = 1; k < NR; k++) begin
            @(negedge clk);
            check("init_done", 32'(bus.init_done), 32'(k == NR - 1));
            if (k < NR - 1) begin
                check("init_wb_ready", 32'(bus.wb_ready), 32'd0);
                check("init_kb_ready", 32'(bus.kb_ready), 32'd0);
            end
            if (k == NR - 2) begin
                bus.wb_valid = 1'b0;
                bus.kb_valid = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.kb_valid = 1'b0; bus.kb_addr = '0; bus.kb_data = '0;
        repeat (2) @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        run_init();

        // Contested requests: wb 2/3/4 (and 5 for RR), kb 9/10/... 
`ifdef RR_ARB_EN
        wi = 0; ki = 0;
        for (int c = 0; c < 8; c++) begin
            step(wi < 4, AW'(2 + wi), 32'h100 + 32'(wi), ki < 4, AW'(9 + ki), 32'h41 + 32'(ki),
                 (c % 2) == 0, (c % 2) == 1);
            if ((c % 2) == 0) wi++; else ki++;
        end
`else
        wi = 0; ki = 0;
        for (int c = 0; c < 3; c++) step(1'b1, AW'(2 + c), 32'h100 + 32'(c), 1'b1, 5'd9, 32'h41, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 5'd9, 32'h41, 1'b0, 1'b1);
`endif
        idle(2);
        check("contest_drained", exp_q.size(), 32'd0);

        step(1'b1, 5'd5, 32'h1234_5678, 1'b0, '0, '0, 1'b1, 1'b0);
        idle(2);
        check("single_drained", exp_q.size(), 32'd0);

        // Injector write to register 0: handshake completes, no write pulse
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'h55, 1'b0, 1'b1);
        idle(2);
        check("zero_drained", exp_q.size(), 32'd0);

        // Back-to-back writeback, including a suppressed register-0 write mid-burst
        step(1'b1, 5'd10, 32'hA0A0_0010, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 5'd0,  32'hA0A0_0000, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 5'd11, 32'hA0A0_0011, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 5'd31, 32'hA0A0_0031, 1'b0, '0, '0, 1'b1, 1'b0);
        idle(2);
        check("burst_drained", exp_q.size(), 32'd0);

        // Reset in RUN with a pending writeback request: the request is dropped
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h7777_7777;
        reset = 1'b1;
        @(negedge clk);
        check_reset_state();
        bus.wb_valid = 1'b0;
        reset = 1'b0;
        for (int k = 1; k < NR; k++) exp_q.push_back(wr_t'{a: AW'(k), d: '0});
        repeat (9) @(negedge clk);
        // Pulse 9 shown, counter now at 10: reset mid-clear
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        run_init();
        idle(2);
        check("final_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
